// File: rtl/mux_4to1_reg_pkg.sv
// Shared constants and select-code names for the registered 4-to-1 selector.
package mux_pkg;

    localparam int MUX4_NUM_IN = 4;
    localparam int MUX4_SEL_W  = 2;

    // Select codes: SEL_Lk steers lane k to the output.
    typedef enum logic [MUX4_SEL_W-1:0] {
        SEL_L0 = 2'd0,
        SEL_L1 = 2'd1,
        SEL_L2 = 2'd2,
        SEL_L3 = 2'd3
    } sel4_t;

endpackage

// File: rtl/mux_4to1_reg_if.sv
// Lane bundle between a producer of packed lanes plus select and the selector.
interface mux_4to1_reg_if
    import mux_pkg::*;
#(
    parameter int DATA_W = 1
);

    logic [MUX4_NUM_IN*DATA_W-1:0] I;
    logic [MUX4_SEL_W-1:0]         Sel;
    logic [DATA_W-1:0]             Y;

    // Producer side: drives lanes and select, observes the registered result.
    modport master (
        output I,
        output Sel,
        input  Y
    );

    // Selector side: consumes lanes and select, drives the registered result.
    modport slave (
        input  I,
        input  Sel,
        output Y
    );

endinterface

// File: rtl/mux_4to1_reg_core.sv
// Purely combinational 4-lane select; lane 0 lives in the LSBs of I.
module mux4_core
    import mux_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic [MUX4_NUM_IN*DATA_W-1:0] I,
    input  logic [MUX4_SEL_W-1:0]         Sel,
    output logic [DATA_W-1:0]             Y
);

    // Steer the addressed lane to Y; every select code is a valid lane.
    always_comb begin
        Y = '0;
        case (sel4_t'(Sel))
            SEL_L0: Y = I[0*DATA_W +: DATA_W];
            SEL_L1: Y = I[1*DATA_W +: DATA_W];
            SEL_L2: Y = I[2*DATA_W +: DATA_W];
            SEL_L3: Y = I[3*DATA_W +: DATA_W];
            default: Y = '0;
        endcase
    end

endmodule

// File: rtl/mux_4to1_reg.sv
// Registered 4-to-1 selector: the chosen lane appears on Y one clock later.
module mux_4to1_reg
    import mux_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_4to1_reg_if.slave  bus
);

    logic [DATA_W-1:0] nextY;

    mux4_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .I   (bus.I),
        .Sel (bus.Sel),
        .Y   (nextY)
    );

    // Output register reloads every edge; a low rst_n at the edge wins and clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.Y <= '0;
        end else begin
            bus.Y <= nextY;
        end
    end

endmodule

// File: tb/tb_mux_4to1_reg.sv
// Directed self-checking bench for mux_4to1_reg at 1-bit and 8-bit lane widths.
module tb_mux_4to1_reg;

    logic clk;
    logic rst_n;
    int   passCount;
    int   checkCount;

    mux_4to1_reg_if #(.DATA_W(1)) busN ();
    mux_4to1_reg_if #(.DATA_W(8)) busW ();

    mux_4to1_reg #(.DATA_W(1)) dutN (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busN)
    );

    mux_4to1_reg #(.DATA_W(8)) dutW (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busW)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive the narrow instance's lanes and select.
    task automatic applyStimulus(input logic [3:0] iVal, input logic [1:0] selVal);
        busN.I   = iVal;
        busN.Sel = selVal;
    endtask

    // Compare one observed output against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    // Narrow step: drive at a falling edge, check at the next falling edge.
    task automatic stepNarrow(input string tag, input logic [3:0] iVal, input logic [1:0] selVal,
                              input logic expY);
        @(negedge clk);
        applyStimulus(iVal, selVal);
        @(negedge clk);
        checkOutput(tag, {7'd0, busN.Y}, {7'd0, expY});
    endtask

    // Wide step on the 8-bit instance.
    task automatic stepWide(input string tag, input logic [1:0] selVal, input logic [7:0] expY);
        @(negedge clk);
        busW.Sel = selVal;
        @(negedge clk);
        checkOutput(tag, busW.Y, expY);
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        rst_n      = 1'b0;
        applyStimulus(4'd15, 2'd2);
        busW.I     = 32'hDDCC_BBAA;
        busW.Sel   = 2'd3;

        // Reset held for two edges with a lane that would otherwise give 1.
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_narrow", {7'd0, busN.Y}, 8'h00);
        checkOutput("reset_wide", busW.Y, 8'h00);

        // Release: first edge with rst_n high loads lane 2 of 15.
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("release", {7'd0, busN.Y}, 8'h01);

        // Bit-select sweep.
        stepNarrow("i15_s2", 4'd15, 2'd2, 1'b1);
        stepNarrow("i0_s0",  4'd0,  2'd0, 1'b0);
        stepNarrow("i5_s1",  4'd5,  2'd1, 1'b0);
        stepNarrow("i12_s2", 4'd12, 2'd2, 1'b1);
        stepNarrow("i5_s0",  4'd5,  2'd0, 1'b1);
        stepNarrow("i7_s2",  4'd7,  2'd2, 1'b1);
        stepNarrow("i8_s1",  4'd8,  2'd1, 1'b0);
        stepNarrow("i10_s2", 4'd10, 2'd2, 1'b0);
        stepNarrow("i8_s2",  4'd8,  2'd2, 1'b0);
        stepNarrow("i12_s3", 4'd12, 2'd3, 1'b1);

        // Latency: settle Y to 0, then change I and Sel mid-cycle.
        stepNarrow("lat_base", 4'd8, 2'd0, 1'b0);
        @(negedge clk);
        applyStimulus(4'd8, 2'd3);
        #1;
        checkOutput("lat_hold_a", {7'd0, busN.Y}, 8'h00);
        applyStimulus(4'd12, 2'd3);
        #1;
        checkOutput("lat_hold_b", {7'd0, busN.Y}, 8'h00);
        @(negedge clk);
        checkOutput("lat_update", {7'd0, busN.Y}, 8'h01);

        // Reset mid-stream while Y is 1.
        stepNarrow("pre_rst", 4'd15, 2'd0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_no_async", {7'd0, busN.Y}, 8'h01);
        @(negedge clk);
        checkOutput("rst_mid", {7'd0, busN.Y}, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_recover", {7'd0, busN.Y}, 8'h01);

        // Wide lanes, I = 0xDDCCBBAA.
        stepWide("wide_s0", 2'd0, 8'hAA);
        stepWide("wide_s1", 2'd1, 8'hBB);
        stepWide("wide_s2", 2'd2, 8'hCC);
        stepWide("wide_s3", 2'd3, 8'hDD);

        // Simultaneous lane and select change on the wide instance.
        @(negedge clk);
        busW.I   = 32'h1122_3344;
        busW.Sel = 2'd1;
        @(negedge clk);
        checkOutput("wide_simul", busW.Y, 8'h33);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
